// File: rtl/sel_mux_reg_if.sv
// Handshake bundle between the requesters/consumer and sel_mux_reg.
// Signal names follow the block's established port names.
interface sel_mux_reg_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4
);
    localparam int unsigned SELW = $clog2(N);

    logic                 Mode;
    logic [SELW-1:0]      Sel;
    logic [N*WIDTH-1:0]   InData;
    logic [N-1:0]         InValid;
    logic [N-1:0]         InReady;
    logic [WIDTH-1:0]     Out;
    logic [SELW-1:0]      OutSrc;
    logic                 OutValid;
    logic                 OutReady;

    // Driver side: requesters plus the output consumer
    modport master (
        output Mode, Sel, InData, InValid, OutReady,
        input  InReady, Out, OutSrc, OutValid
    );

    // Selector side
    modport slave (
        input  Mode, Sel, InData, InValid, OutReady,
        output InReady, Out, OutSrc, OutValid
    );
endinterface

// File: rtl/sel_mux_reg.sv
// N-input selector with a one-entry registered output, valid/ready on both sides,
// and a fixed-select or round-robin grant. Grant is combinational; data path is registered.
module sel_mux_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    sel_mux_reg_if.slave  bus
);
    localparam int unsigned SELW = $clog2(N);

    logic [WIDTH-1:0] out_q,       out_d;
    logic [SELW-1:0]  out_src_q,   out_src_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    logic             space_c;
    logic [SELW-1:0]  rr_grant_c;
    logic             rr_found_c;
    logic [SELW-1:0]  grant_c;
    logic             grant_ok_c;
    logic [N-1:0]     in_ready_c;
    logic             accept_c;
    logic [WIDTH-1:0] sel_data_c;

    assign space_c = !out_valid_q || bus.OutReady;

    // Round-robin scan starting at ptr_q, wrapping modulo N
    always_comb begin
        rr_found_c = 1'b0;
        rr_grant_c = '0;
        for (int unsigned k = 0; k < N; k++) begin
            logic [SELW:0]   sum;
            logic [SELW-1:0] idx;
            sum = {1'b0, ptr_q} + (SELW+1)'(k);
            if (sum >= (SELW+1)'(N)) begin
                sum = sum - (SELW+1)'(N);
            end
            idx = SELW'(sum);
            if (!rr_found_c && bus.InValid[idx]) begin
                rr_found_c = 1'b1;
                rr_grant_c = idx;
            end
        end
    end

    always_comb begin
        grant_c    = '0;
        grant_ok_c = 1'b0;
        if (bus.Mode) begin
            grant_c    = rr_grant_c;
            grant_ok_c = rr_found_c;
        end else begin
            grant_c    = bus.Sel;
            grant_ok_c = (32'(bus.Sel) < N);
        end
    end

    // Reset blocks acceptance so a pulsed reset never swallows an input
    always_comb begin
        in_ready_c = '0;
        if (!Reset && space_c && grant_ok_c) begin
            in_ready_c = N'(1) << grant_c;
        end
    end

    assign accept_c = |(bus.InValid & in_ready_c);

    always_comb begin
        sel_data_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (SELW'(i) == grant_c) begin
                sel_data_c = bus.InData[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state: accept overrides pop, giving one item per cycle
    always_comb begin
        out_d       = out_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (accept_c) begin
            out_d       = sel_data_c;
            out_src_d   = grant_c;
            out_valid_d = 1'b1;
            if (bus.Mode) begin
                ptr_d = (grant_c == SELW'(N-1)) ? '0 : grant_c + SELW'(1);
            end
        end else if (bus.OutReady) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_q       <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_q       <= out_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.InReady  = in_ready_c;
    assign bus.Out      = out_q;
    assign bus.OutSrc   = out_src_q;
    assign bus.OutValid = out_valid_q;
endmodule
